// File: rtl/alu_operand_loader.sv
// Push-button front end for the ALU demo: synchronises and debounces the keys, then
// sequences operand A, operand B and the opcode into a valid/ready hand-off.
// Optional SWAP key (exchange A/B while in LOAD_OP) is built when ALU_LOADER_SWAP_EN is defined.
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DW              = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [3:0]    key_n,
  input  logic [17:0]   sw,
  input  logic          op_ready,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [3:0]    aluop_out,
  output logic          op_valid,
  output logic [1:0]    state_out,
  output logic [3:0]    key_evt
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    ISSUE   = 2'd3
  } state_t;

`ifdef ALU_LOADER_SWAP_EN
  localparam int NK = 3;
`else
  localparam int NK = 2;
`endif

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NK-1:0] sync1, sync2, db, evt;
  logic [CW-1:0] cnt [NK];

  state_t        state_q, state_d;
  logic          enter, cancel;
  logic [DW-1:0] sext;

  // Inputs with no function in this build; folded away to keep lint quiet.
  logic unused_bits;
  assign unused_bits = ^{key_n[3:NK], sw[17]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order in the block.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      evt   <= '0;
      for (int i = 0; i < NK; i++) cnt[i] <= '0;
    end else begin
      sync1 <= key_n[NK-1:0];
      sync2 <= sync1;
      evt   <= '0;
      for (int i = 0; i < NK; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          // Level accepted; a 1->0 transition is a press and fires the event
          // in the same cycle the debounced level flips.
          db[i]  <= sync2[i];
          cnt[i] <= '0;
          evt[i] <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign key_evt = 4'(evt);
  assign enter   = evt[0];
  assign cancel  = evt[1];
  assign sext    = {{(DW-16){sw[16]}}, sw[15:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= LOAD_A;
    else       state_q <= state_d;
  end

  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  if (cancel) state_d = LOAD_A;
               else if (enter) state_d = LOAD_B;
      LOAD_B:  if (cancel) state_d = LOAD_A;
               else if (enter) state_d = LOAD_OP;
      LOAD_OP: if (cancel) state_d = LOAD_A;
               else if (enter) state_d = ISSUE;
      ISSUE:   if (op_ready) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // Valid is a pure function of state, so it drops with the async reset.
  always_comb begin
    state_out = state_q;
    op_valid  = (state_q == ISSUE);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      a_out     <= '0;
      b_out     <= '0;
      aluop_out <= '0;
    end else if (enter && !cancel) begin
      case (state_q)
        LOAD_A:  a_out     <= sext;
        LOAD_B:  b_out     <= sext;
        LOAD_OP: aluop_out <= sw[3:0];
        default: ;
      endcase
    end
`ifdef ALU_LOADER_SWAP_EN
    else if (evt[2] && !cancel && state_q == LOAD_OP) begin
      a_out <= b_out;
      b_out <= a_out;
    end
`endif
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with DEBOUNCE_CYCLES=4; inputs driven and
// outputs sampled on the falling clock edge.
module tb_alu_operand_loader;

  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [3:0]    key_n;
  logic [17:0]   sw;
  logic          op_ready;
  logic [DW-1:0] a_out, b_out;
  logic [3:0]    aluop_out;
  logic          op_valid;
  logic [1:0]    state_out;
  logic [3:0]    key_evt;

  int n_total = 0;
  int n_pass  = 0;
  int evt_cnt [4];

  alu_operand_loader #(.DEBOUNCE_CYCLES(4), .DW(DW)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .key_n     (key_n),
    .sw        (sw),
    .op_ready  (op_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .aluop_out (aluop_out),
    .op_valid  (op_valid),
    .state_out (state_out),
    .key_evt   (key_evt)
  );

  always #5 CLK = ~CLK;

  initial for (int i = 0; i < 4; i++) evt_cnt[i] = 0;

  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) if (key_evt[i] === 1'b1) evt_cnt[i] = evt_cnt[i] + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Hold the masked keys pressed for 10 cycles, then release and let the debouncers settle.
  task automatic press(input logic [3:0] mask);
    key_n = 4'hF & ~mask;
    cycles(10);
    key_n = 4'hF;
    cycles(10);
  endtask

  initial begin
    int e0, e1, e2, first;
    nRST     = 1'b0;
    key_n    = 4'hF;
    sw       = '0;
    op_ready = 1'b0;
    cycles(3);
    nRST = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      check("reset_idle", {state_out, op_valid, a_out, b_out, key_evt},
            {2'd0, 1'b0, 32'h0, 32'h0, 4'h0});
    end

    // 3-cycle glitch must not produce an event.
    sw = 18'h1_0005;
    e0 = evt_cnt[0];
    key_n[0] = 1'b0;
    cycles(3);
    key_n[0] = 1'b1;
    cycles(12);
    check("glitch_no_evt", 64'(evt_cnt[0] - e0), 64'd0);
    check("glitch_state", 64'(state_out), 64'd0);

    // Long hold: one pulse, 6 cycles after the press; also loads A.
    e0 = evt_cnt[0];
    first = 0;
    key_n[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cycles(1);
      if (key_evt[0] === 1'b1 && first == 0) first = i;
      if (i == 10) key_n[0] = 1'b1;
    end
    check("evt_latency", 64'(first), 64'd6);
    check("evt_once", 64'(evt_cnt[0] - e0), 64'd1);
    check("load_a_val", 64'(a_out), 64'hFFFF_0005);
    check("load_a_state", 64'(state_out), 64'd1);

    sw = 18'h0_00FF;
    press(4'b0001);
    check("load_b_val", 64'(b_out), 64'h0000_00FF);
    check("load_b_state", 64'(state_out), 64'd2);

    sw = 18'h0_0003;
    press(4'b0001);
    check("load_op_val", 64'(aluop_out), 64'd3);
    check("load_op_valid", 64'(op_valid), 64'd1);
    check("load_op_state", 64'(state_out), 64'd3);

    // ISSUE holds without op_ready; CANCEL and ENTER are ignored.
    e1 = evt_cnt[1];
    press(4'b0010);
    check("issue_cancel_evt", 64'(evt_cnt[1] - e1), 64'd1);
    press(4'b0001);
    check("issue_hold", {op_valid, state_out, aluop_out, a_out[15:0], b_out[15:0]},
          {1'b1, 2'd3, 4'd3, 16'h0005, 16'h00FF});
    check("issue_hold_a", 64'(a_out), 64'hFFFF_0005);

    // Transfer.
    op_ready = 1'b1;
    cycles(1);
    op_ready = 1'b0;
    check("xfer_valid", 64'(op_valid), 64'd0);
    check("xfer_state", 64'(state_out), 64'd0);
    check("xfer_a_kept", 64'(a_out), 64'hFFFF_0005);

    // op_ready with nothing pending is ignored.
    op_ready = 1'b1;
    cycles(2);
    op_ready = 1'b0;
    check("ready_idle", {op_valid, state_out}, {1'b0, 2'd0});

    // ENTER + CANCEL together in LOAD_B: CANCEL wins.
    sw = 18'h0_0005;
    press(4'b0001);
    check("a5_state", 64'(state_out), 64'd1);
    sw = 18'h0_0009;
    press(4'b0011);
    check("both_state", 64'(state_out), 64'd0);
    check("both_b_kept", 64'(b_out), 64'h0000_00FF);
    check("both_a_kept", 64'(a_out), 64'h0000_0005);

    // SWAP in LOAD_OP.
    sw = 18'h0_0005;
    press(4'b0001);
    sw = 18'h0_0009;
    press(4'b0001);
    check("pre_swap_state", 64'(state_out), 64'd2);
    e2 = evt_cnt[2];
    press(4'b0100);
`ifdef ALU_LOADER_SWAP_EN
    check("swap_evt", 64'(evt_cnt[2] - e2), 64'd1);
    check("swap_ab", {a_out, b_out}, {32'd9, 32'd5});
`else
    check("swap_evt", 64'(evt_cnt[2] - e2), 64'd0);
    check("swap_ab", {a_out, b_out}, {32'd5, 32'd9});
`endif
    check("swap_state", 64'(state_out), 64'd2);
    check("key3_never", 64'(evt_cnt[3]), 64'd0);

    // CANCEL in LOAD_OP returns to LOAD_A keeping captures.
    press(4'b0010);
    check("cancel_op_state", 64'(state_out), 64'd0);
`ifdef ALU_LOADER_SWAP_EN
    check("cancel_op_kept", {a_out, b_out}, {32'd9, 32'd5});
`else
    check("cancel_op_kept", {a_out, b_out}, {32'd5, 32'd9});
`endif

    // Async reset in ISSUE.
    sw = 18'h1_FFFF;
    press(4'b0001);
    press(4'b0001);
    sw = 18'h0_000A;
    press(4'b0001);
    check("pre_rst_issue", {op_valid, state_out, aluop_out}, {1'b1, 2'd3, 4'hA});
    check("pre_rst_b", 64'(b_out), 64'hFFFF_FFFF);
    #2;
    nRST = 1'b0;
    #1;
    check("async_rst", {op_valid, state_out, a_out, b_out, aluop_out, key_evt},
          {1'b0, 2'd0, 32'h0, 32'h0, 4'h0, 4'h0});
    cycles(2);
    nRST = 1'b1;
    cycles(2);
    check("post_rst", {op_valid, state_out}, {1'b0, 2'd0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
